pr_icap_loader: RTL and testbench

Streams a partial bitstream from the PS-side word bus into the FPGA configuration port (ICAPE2) and isolates the reconfigurable partition while it is rewritten. It sits directly upstream of `PartialReconfigurationTop`: it drives the `decouple` input that partition top uses to freeze its boundary, and it reports completion so the partition can be released. A small internal FIFO absorbs bus burstiness, and the block applies the ICAP per-byte bit-swap.

---
 rtl/pr_pkg.sv | 33 +++
 rtl/pr_sync_fifo.sv | 71 +++++++
 rtl/pr_icap_loader.sv | 177 +++++++++++++++++
 tb/tb_pr_icap_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// -----------------------------------------------------------------------------
// pr_pkg
// Shared definitions for the partial-reconfiguration ICAP loader family:
//   - pr_state_e    : loader FSM states
//   - CSIB_IDLE     : ICAP chip-select level when no write is presented
//   - RDWRB_WRITE   : ICAP rdwrb level selecting a write
//   - icap_bitswap(): per-byte bit reversal required by ICAPE2
// -----------------------------------------------------------------------------
package pr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DONE    = 3'd4
  } pr_state_e;

  localparam logic CSIB_IDLE   = 1'b1;
  localparam logic RDWRB_WRITE = 1'b0;

  // ICAPE2 expects each byte bit-reversed; byte order itself is untouched.
  function automatic logic [31:0] icap_bitswap(input logic [31:0] din);
    logic [31:0] dout;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        dout[8*k+j] = din[8*k+7-j];
      end
    end
    return dout;
  endfunction

endpackage

// File: rtl/pr_sync_fifo.sv
// -----------------------------------------------------------------------------
// pr_sync_fifo
// Single-clock FIFO with synchronous flush. Read data is combinational from the
// head entry; when empty, the write data is passed straight through so that a
// simultaneous push and pop leaves the occupancy unchanged.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_flush           : empty the FIFO (wins over push/pop)
//   i_push, i_data    : write request and data
//   i_pop             : read request (head advances)
//   o_data            : head entry
//   o_full, o_empty   : occupancy flags
// DEPTH must be a power of two.
// -----------------------------------------------------------------------------
module pr_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Full + pop frees a slot for the push; empty + push supplies the pop.
  assign w_push = i_push && (!o_full  || i_pop);
  assign w_pop  = i_pop  && (!o_empty || i_push);

  assign o_data = o_empty ? i_data : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pr_icap_loader.sv
// -----------------------------------------------------------------------------
// pr_icap_loader
// Streams a partial bitstream from a valid/ready word bus into ICAPE2 while
// holding the reconfigurable partition decoupled.
// Ports:
//   CLK, RST_n          : clock, asynchronous active-low reset
//   start, length       : begin a load of `length` words (sampled in IDLE)
//   abort               : abandon the load in progress (ignored in IDLE)
//   s_valid/s_data/s_ready : bitstream word stream, bus byte order
//   icap_csib/icap_rdwrb/icap_i : ICAPE2 write port (data bit-swapped)
//   decouple            : isolation request to the partition top
//   busy, done, err     : status; done/err are one-cycle pulses
//   sent_cnt            : words written to ICAP in the current load
// -----------------------------------------------------------------------------
module pr_icap_loader
  import pr_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 24,
  parameter int ISO_CYC    = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i,
  output logic             decouple,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] sent_cnt
);

  localparam int CYC_MAX = (ISO_CYC > SETTLE_CYC) ? ISO_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] ISO_LAST    = CYC_W'(ISO_CYC - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  pr_state_e        r_state;
  pr_state_e        w_next;
  logic [CYC_W-1:0] r_cyc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_acc;
  logic [LEN_W-1:0] r_sent;
  logic             r_csib;
  logic             r_rdwrb;
  logic [31:0]      r_icap_i;
  logic             r_rm_invalid;
  logic             r_decouple;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_active;
  logic             w_abort;
  logic             w_start_ok;
  logic             w_start_zero;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic             w_rm_next;
  logic [31:0]      w_fifo_data;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_active     = (r_state == ST_ISOLATE) || (r_state == ST_LOAD) ||
                        (r_state == ST_SETTLE);
  assign w_abort      = abort && w_active;
  assign w_start_ok   = (r_state == ST_IDLE) && start && (length != '0);
  assign w_start_zero = (r_state == ST_IDLE) && start && (length == '0);

  // Word `length` is on the ICAP port this cycle; nothing further can follow
  // because acceptance stops at `length`.
  assign w_last = (r_state == ST_LOAD) && !r_csib && (r_sent == r_len);

  assign s_ready = (r_state == ST_LOAD) && !w_fifo_full && (r_acc < r_len);
  assign w_push  = s_valid && s_ready;
  assign w_pop   = (r_state == ST_LOAD) && !w_fifo_empty && !abort;

  // rm_invalid is sticky across aborts and only a completed load clears it.
  assign w_rm_next = w_abort ? 1'b1 :
                     (r_state == ST_DONE) ? 1'b0 : r_rm_invalid;

  pr_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_n),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // NOTE: the next-state default is assigned before the case so that no path
  // leaves w_next unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok)           w_next = ST_ISOLATE;
      ST_ISOLATE: if (r_cyc == ISO_LAST)    w_next = ST_LOAD;
      ST_LOAD:    if (w_last)               w_next = ST_SETTLE;
      ST_SETTLE:  if (r_cyc == SETTLE_LAST) w_next = ST_DONE;
      ST_DONE:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= ST_IDLE;
      r_cyc        <= '0;
      r_len        <= '0;
      r_acc        <= '0;
      r_sent       <= '0;
      r_csib       <= CSIB_IDLE;
      r_rdwrb      <= 1'b1;
      r_icap_i     <= '0;
      r_rm_invalid <= 1'b0;
      r_decouple   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;

      // Shared cycle counter for ISOLATE and SETTLE, restarted on every state change.
      if (w_next != r_state)                              r_cyc <= '0;
      else if (r_state == ST_ISOLATE || r_state == ST_SETTLE) r_cyc <= r_cyc + CYC_ONE;

      if (w_start_ok) begin
        r_len  <= length;
        r_acc  <= '0;
        r_sent <= '0;
      end else begin
        if (w_push) r_acc  <= r_acc + LEN_ONE;
        if (w_pop)  r_sent <= r_sent + LEN_ONE;
      end

      r_csib <= w_pop ? 1'b0 : CSIB_IDLE;
      if (w_pop) begin
        r_icap_i <= icap_bitswap(w_fifo_data);
        r_rdwrb  <= RDWRB_WRITE;
      end

      r_rm_invalid <= w_rm_next;
      r_decouple   <= (w_next != ST_IDLE) || w_rm_next;
      r_busy       <= (w_next != ST_IDLE);
      r_done       <= (w_next == ST_DONE);
      r_err        <= w_abort || w_start_zero;
    end
  end

  assign icap_csib  = r_csib;
  assign icap_rdwrb = r_rdwrb;
  assign icap_i     = r_icap_i;
  assign decouple   = r_decouple;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign sent_cnt   = r_sent;

endmodule

// File: tb/tb_pr_icap_loader.sv
// -----------------------------------------------------------------------------
// tb_pr_icap_loader
// Self-checking bench: a queue-based reference model of the loader is stepped
// on every clock edge and compared with the DUT on every falling edge; directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pr_icap_loader;

  localparam int DEPTH = 16;
  localparam int LW    = 24;
  localparam int ISO   = 8;
  localparam int SET   = 16;

  localparam int V_CONT  = 0;
  localparam int V_BURST = 1;
  localparam int V_RAND  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] length = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready;
  logic          icap_csib;
  logic          icap_rdwrb;
  logic [31:0]   icap_i;
  logic          decouple;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] sent_cnt;

  pr_icap_loader #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW),
    .ISO_CYC    (ISO),
    .SETTLE_CYC (SET)
  ) dut (
    .CLK        (clk),
    .RST_n      (rst_n),
    .start      (start),
    .length     (length),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .icap_csib  (icap_csib),
    .icap_rdwrb (icap_rdwrb),
    .icap_i     (icap_i),
    .decouple   (decouple),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sent_cnt   (sent_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ISO, M_LOAD, M_SETTLE, M_DONE} mph_e;
  mph_e        ph = M_IDLE;
  int          timer = 0;
  int          len_m = 0;
  int          acc_m = 0;
  int          sent_m = 0;
  bit          rm_m = 1'b0;
  logic [31:0] fq[$];
  logic        e_csib = 1'b1;
  logic [31:0] e_icap = '0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;
  bit          m_acc;
  bit          m_abort;

  // Per-byte bit reversal = whole-word bit reversal followed by byte reversal.
  function automatic logic [31:0] swap_ref(input logic [31:0] w);
    logic [31:0] rev;
    rev = {<<{w}};
    return {<<8{rev}};
  endfunction

  function automatic bit m_sready();
    return (ph == M_LOAD) && (acc_m < len_m) && (fq.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_IDLE; timer = 0; len_m = 0; acc_m = 0; sent_m = 0; rm_m = 1'b0;
      fq.delete();
      e_csib = 1'b1; e_icap = '0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      m_acc   = s_valid && m_sready();
      m_abort = abort && (ph == M_ISO || ph == M_LOAD || ph == M_SETTLE);
      e_done  = 1'b0;
      e_err   = 1'b0;
      if (m_abort) begin
        fq.delete();
        e_csib = 1'b1; e_err = 1'b1; rm_m = 1'b1; ph = M_IDLE;
      end else begin
        case (ph)
          M_IDLE: begin
            e_csib = 1'b1;
            if (start) begin
              if (length == 0) e_err = 1'b1;
              else begin
                len_m = int'(length); acc_m = 0; sent_m = 0; ph = M_ISO; timer = ISO;
              end
            end
          end
          M_ISO: begin
            e_csib = 1'b1;
            timer--;
            if (timer == 0) ph = M_LOAD;
          end
          M_LOAD: begin
            if (e_csib == 1'b0 && sent_m == len_m) begin
              ph = M_SETTLE; timer = SET; e_csib = 1'b1;
            end else begin
              if (fq.size() > 0) begin
                e_icap = swap_ref(fq.pop_front()); e_csib = 1'b0; sent_m++;
              end else e_csib = 1'b1;
              if (m_acc) begin fq.push_back(s_data); acc_m++; end
            end
          end
          M_SETTLE: begin
            e_csib = 1'b1;
            timer--;
            if (timer == 0) begin ph = M_DONE; e_done = 1'b1; end
          end
          M_DONE: begin
            e_csib = 1'b1; ph = M_IDLE; rm_m = 1'b0;
          end
          default: ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          cyc = 0;
  int          last_wr = 0;
  int          done_at = 0;
  logic [31:0] obs[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      check("s_ready", s_ready, m_sready());
      check("icap_csib", icap_csib, e_csib);
      if (!e_csib) check("icap_i", icap_i, e_icap);
      check("no_readback", (!icap_csib && icap_rdwrb), 1'b0);
      check("busy", busy, ph != M_IDLE);
      check("decouple", decouple, (ph != M_IDLE) || rm_m);
      check("done", done, e_done);
      check("err", err, e_err);
      check("sent_cnt", sent_cnt, sent_m);
      if (!icap_csib) begin obs.push_back(icap_i); last_wr = cyc; end
      if (done) done_at = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] words [64];

  function automatic bit pick_valid(input int mode, input int n);
    case (mode)
      V_CONT:  return 1'b1;
      V_BURST: return (n % 8) < 3;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1; length = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer n words; optionally abort when `abort_at` words have been accepted,
  // or pulse an (ignored) start when `start_at` words have been accepted.
  task automatic feed(input int n, input int mode, input int abort_at, input int start_at);
    int k = 0;
    int cnt = 0;
    bit hs;
    bit fired = 1'b0;
    while (k < n && cnt < 4000) begin
      @(negedge clk);
      if (k == abort_at) begin
        s_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      if (k == start_at && !fired) begin start = 1'b1; length = LW'(3); fired = 1'b1; end
      else start = 1'b0;
      s_valid = pick_valid(mode, cnt);
      s_data  = words[k];
      hs = s_valid && s_ready;
      @(posedge clk);
      if (hs) k++;
      cnt++;
    end
    @(negedge clk);
    s_valid = 1'b0; start = 1'b0;
    if (k < n) check("feed_timeout", k, n);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},  s_ready,    1'b0);
    check({tag, "_csib"},     icap_csib,  1'b1);
    check({tag, "_rdwrb"},    icap_rdwrb, 1'b1);
    check({tag, "_icap_i"},   icap_i,     32'h0);
    check({tag, "_decouple"}, decouple,   1'b0);
    check({tag, "_busy"},     busy,       1'b0);
    check({tag, "_done"},     done,       1'b0);
    check({tag, "_err"},      err,        1'b0);
    check({tag, "_sent_cnt"}, sent_cnt,   '0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int len;
    int ab;

    #1 rst_n = 1'b0;
    #2 check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal load with the literal vector set.
    words[0] = 32'h01234567; words[1] = 32'h89ABCDEF;
    words[2] = 32'hAA995566; words[3] = 32'h20000000;
    obs.delete();
    do_start(4);
    feed(4, V_CONT, -1, -1);
    wait_idle(200);
    check("n_writes", obs.size(), 4);
    if (obs.size() == 4) begin
      check("word0", obs[0], 32'h80C4A2E6);
      check("word1", obs[1], 32'h91D5B3F7);
      check("word2", obs[2], 32'h5599AA66);
      check("word3", obs[3], 32'h04000000);
    end
    check("done_delay", done_at - last_wr, SET + 1);
    check("dec_after_done", decouple, 1'b0);

    // Zero-length start.
    do_start(0);
    check("zero_err", err, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_dec", decouple, 1'b0);
    check("zero_csib", icap_csib, 1'b1);
    @(negedge clk);
    check("zero_err_width", err, 1'b0);

    // Bursty source, then hold s_valid high past the last word.
    fill_random(41);
    obs.delete();
    do_start(40);
    feed(40, V_BURST, -1, -1);
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    wait_idle(400);
    s_valid = 1'b0;
    check("burst_sent", sent_cnt, 40);
    check("burst_writes", obs.size(), 40);

    // Abort after 10 of 20 words.
    fill_random(20);
    do_start(20);
    feed(20, V_CONT, 10, -1);
    check("abort_err", err, 1'b1);
    check("abort_csib", icap_csib, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_dec_held", decouple, 1'b1);
    fill_random(2);
    do_start(2);
    feed(2, V_CONT, -1, -1);
    wait_idle(200);
    check("reload_dec", decouple, 1'b0);

    // Abort during SETTLE.
    fill_random(3);
    do_start(3);
    feed(3, V_CONT, -1, -1);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("settle_abort_dec", decouple, 1'b1);
    fill_random(1);
    do_start(1);
    feed(1, V_CONT, -1, -1);
    wait_idle(200);
    check("settle_abort_release", decouple, 1'b0);

    // Start pulsed during LOAD is ignored.
    fill_random(12);
    obs.delete();
    do_start(12);
    feed(12, V_CONT, -1, 5);
    wait_idle(200);
    check("ign_start_sent", sent_cnt, 12);
    check("ign_start_writes", obs.size(), 12);

    // Asynchronous reset mid-load, then a fresh load.
    fill_random(20);
    do_start(20);
    feed(6, V_CONT, -1, -1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random(3);
    obs.delete();
    do_start(3);
    feed(3, V_RAND, -1, -1);
    wait_idle(200);
    check("fresh_sent", sent_cnt, 3);
    check("fresh_writes", obs.size(), 3);
    check("fresh_dec", decouple, 1'b0);

    // Randomised loads, some aborted.
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(1, 30));
      fill_random(len);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      do_start(len);
      feed(len, V_RAND, ab, -1);
      wait_idle(400);
    end
    fill_random(5);
    do_start(5);
    feed(5, V_RAND, -1, -1);
    wait_idle(400);
    check("final_sent", sent_cnt, 5);
    check("final_dec", decouple, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
